// File: rtl/fpmul_result_collector_if.sv
// Handshake bundle between FPmul issue/drain logic and the result collector.
// master: producer/consumer side; slave: the collector.
interface fpmul_result_collector_if #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
);
    localparam int OCC_W = $clog2(DEPTH) + 1;

    logic              in_vld;
    logic              in_rdy;
    logic [DATA_W-1:0] mul_z;
    logic [DATA_W-1:0] out_data;
    logic              out_vld;
    logic              out_rdy;
    logic [OCC_W-1:0]  occ;
    logic              issue_err;
    logic [15:0]       res_cnt;

    modport master (
        output in_vld,
        output mul_z,
        output out_rdy,
        input  in_rdy,
        input  out_data,
        input  out_vld,
        input  occ,
        input  issue_err,
        input  res_cnt
    );

    modport slave (
        input  in_vld,
        input  mul_z,
        input  out_rdy,
        output in_rdy,
        output out_data,
        output out_vld,
        output occ,
        output issue_err,
        output res_cnt
    );
endinterface

// File: rtl/fpmul_result_collector.sv
// Collects FPmul products into a FWFT FIFO using a LAT-deep valid pipe and
// issue credits. Ports: clk_i, rst_i (sync, active-high), bus (slave modport).
module fpmul_result_collector #(
    parameter int DATA_W = 32,
    parameter int LAT    = 4,
    parameter int DEPTH  = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    fpmul_result_collector_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int OCC_W = PTR_W + 1;

    logic [LAT-1:0]    vp_q, vp_d;
    logic [PTR_W-1:0]  wr_q, wr_d;
    logic [PTR_W-1:0]  rd_q, rd_d;
    logic [OCC_W-1:0]  occ_q, occ_d;
    logic [OCC_W-1:0]  cred_q, cred_d;
    logic              err_q, err_d;
    logic [15:0]       cnt_q, cnt_d;
    logic [DATA_W-1:0] mem_q [DEPTH];

    logic issue;
    logic pop;
    logic push;

    assign issue = bus.in_vld & bus.in_rdy;
    assign pop   = bus.out_vld & bus.out_rdy;
    // Tail of the valid pipe lines up with the product on mul_z.
    assign push  = vp_q[LAT-1];

    generate
        if (LAT == 1) begin : g_vp1
            assign vp_d = issue;
        end else begin : g_vpn
            assign vp_d = {vp_q[LAT-2:0], issue};
        end
    endgenerate

    always_comb begin
        wr_d   = wr_q;
        rd_d   = rd_q;
        occ_d  = occ_q;
        cred_d = cred_q;
        err_d  = err_q | (bus.in_vld & ~bus.in_rdy);
        cnt_d  = cnt_q;
        if (push) begin
            wr_d = wr_q + PTR_W'(1);
        end
        if (pop) begin
            rd_d  = rd_q + PTR_W'(1);
            cnt_d = cnt_q + 16'd1;
        end
        unique case ({push, pop})
            2'b10:   occ_d = occ_q + OCC_W'(1);
            2'b01:   occ_d = occ_q - OCC_W'(1);
            default: occ_d = occ_q;
        endcase
        // Credits cover FIFO slots plus products still in flight.
        unique case ({issue, pop})
            2'b10:   cred_d = cred_q - OCC_W'(1);
            2'b01:   cred_d = cred_q + OCC_W'(1);
            default: cred_d = cred_q;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            vp_q   <= '0;
            wr_q   <= '0;
            rd_q   <= '0;
            occ_q  <= '0;
            cred_q <= OCC_W'(DEPTH);
            err_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            vp_q   <= vp_d;
            wr_q   <= wr_d;
            rd_q   <= rd_d;
            occ_q  <= occ_d;
            cred_q <= cred_d;
            err_q  <= err_d;
            cnt_q  <= cnt_d;
        end
    end

    // Storage needs no reset; pointers and occupancy define validity.
    always_ff @(posedge clk_i) begin
        if (!rst_i && push) begin
            mem_q[wr_q] <= bus.mul_z;
        end
    end

    assign bus.in_rdy    = (cred_q != '0);
    assign bus.out_vld   = (occ_q != '0);
    assign bus.out_data  = mem_q[rd_q];
    assign bus.occ       = occ_q;
    assign bus.issue_err = err_q;
    assign bus.res_cnt   = cnt_q;
endmodule
